anode_scanner: RTL and testbench

Time-multiplexed digit scanner for the 4-digit common-anode seven-segment display. It produces the active-low one-hot anode pattern consumed by the downstream segment decoder. The decoder uses that pattern to pick the operand (A, B, A+B or A−B) whose glyph it drives. Each digit slot starts with a dead-time blank, so the decoder's select path settles before the digit lights and adjacent digits do not ghost. A per-digit mask suppresses unused digits.

---
 rtl/anode_scanner_if.sv | 44 ++++
 rtl/anode_scanner.sv | 149 ++++++++++++++
 tb/tb_anode_scanner.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/anode_scanner_if.sv
// ----------------------------------------------------------------------------
// anode_scanner_if
//
// Purpose:
//   Bundles the control inputs and the display-drive outputs of the
//   seven-segment anode scanner so the scanner, its controller and the
//   downstream segment decoder can share one connection.
//
// Signals:
//   en          scan enable; 0 = display off
//   digit_mask  bit i = 1 shows digit i, 0 keeps that anode off
//   anode       active-low one-hot anode drive (1111 = all off)
//   digit_idx   index of the current digit slot, 0..3
//   tick        one-cycle pulse on the final cycle of each slot
//
// Modports:
//   master  the side that drives en/digit_mask and observes the scan outputs
//   slave   the scanner itself
// ----------------------------------------------------------------------------
interface anode_scanner_if;

   logic       en;
   logic [3:0] digit_mask;
   logic [3:0] anode;
   logic [1:0] digit_idx;
   logic       tick;

   modport master (
      output en,
      output digit_mask,
      input  anode,
      input  digit_idx,
      input  tick
   );

   modport slave (
      input  en,
      input  digit_mask,
      output anode,
      output digit_idx,
      output tick
   );

endinterface

// File: rtl/anode_scanner.sv
// ----------------------------------------------------------------------------
// anode_scanner
//
// Purpose:
//   Time-multiplexed digit scanner for a 4-digit common-anode seven-segment
//   display. Each digit slot lasts DIV_COUNT cycles. The first BLANK_CYCLES
//   cycles of every slot keep all anodes off, so the downstream decoder's
//   operand select settles before the digit lights and neighbouring digits
//   do not ghost. The remaining cycles drive the active-low one-hot anode of
//   the current digit, unless digit_mask suppresses it.
//
// Parameters:
//   DIV_COUNT     clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  dead-time cycles at the start of each slot (< DIV_COUNT)
//   CNT_W         slot counter width, 2**CNT_W >= DIV_COUNT
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   scan      anode_scanner_if.slave:
//                en, digit_mask (in); anode, digit_idx, tick (out)
//
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module anode_scanner #(
   parameter int DIV_COUNT    = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int CNT_W        = 17
) (
   input  logic            clk,
   input  logic            reset_n,
   anode_scanner_if.slave  scan
);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_t;

   // Last counter value of a slot and of its blank window. The blank
   // constant is clamped so it stays legal when there is no blank window;
   // BLANK is never entered in that case.
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_COUNT - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST =
      CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
   localparam bit               HAS_BLANK  = (BLANK_CYCLES > 0);

   state_t           state_q;
   state_t           state_next;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       idx_q;
   logic [1:0]       idx_next;
   logic [3:0]       anode_q;
   logic [3:0]       anode_next;
   logic             tick_q;
   logic             tick_next;
   logic [3:0]       onehot;

   // State, slot counter, digit index and the registered outputs. Reset
   // forces the display dark at once, independent of the clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         anode_q <= 4'b1111;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_next;
         cnt_q   <= cnt_next;
         idx_q   <= idx_next;
         anode_q <= anode_next;
         tick_q  <= tick_next;
      end
   end

   // Next-state logic. Dropping en from any state discards the slot in
   // progress, so a later enable always restarts at digit 0 with a full
   // slot. The counter runs continuously through BLANK into SHOW; only the
   // slot boundary clears it and advances the digit.
   always_comb begin
      state_next = state_q;
      cnt_next   = cnt_q;
      idx_next   = idx_q;

      if (!scan.en) begin
         state_next = IDLE;
         cnt_next   = '0;
         idx_next   = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_next   = '0;
               idx_next   = 2'd0;
               state_next = HAS_BLANK ? BLANK : SHOW;
            end
            BLANK: begin
               cnt_next = cnt_q + CNT_W'(1);
               if (cnt_q == BLANK_LAST) begin
                  state_next = SHOW;
               end
            end
            SHOW: begin
               if (cnt_q == DIV_LAST) begin
                  cnt_next   = '0;
                  idx_next   = idx_q + 2'd1;
                  state_next = HAS_BLANK ? BLANK : SHOW;
               end else begin
                  cnt_next = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = 2'd0;
            end
         endcase
      end
   end

   // Output decode, computed from the upcoming state so anode and tick line
   // up with the registered state. The mask is sampled every cycle, so a
   // mask change shows on the very next cycle without touching the counter.
   // Only a single zero bit or all ones can ever be produced here.
   always_comb begin
      onehot     = 4'b0001 << idx_next;
      anode_next = 4'b1111;
      tick_next  = 1'b0;

      if (state_next == SHOW) begin
         if (scan.digit_mask[idx_next]) begin
            anode_next = ~onehot;
         end
         tick_next = (cnt_next == DIV_LAST);
      end
   end

   assign scan.anode     = anode_q;
   assign scan.digit_idx = idx_q;
   assign scan.tick      = tick_q;

   // The decoder relies on anode being dark or selecting exactly one digit.
   anode_one_cold: assert property (
      @(posedge clk) disable iff (!reset_n) $onehot0(~anode_q)
   );

endmodule

// File: tb/tb_anode_scanner.sv
// ----------------------------------------------------------------------------
// tb_anode_scanner
//
// Purpose:
//   Self-checking bench for anode_scanner. Three instances run side by side:
//   A with an 8-cycle slot and 2 blank cycles, B with an 8-cycle slot and no
//   blank, C with the default 100000/1000 timing (only its first slot start
//   is exercised). The stimulus process pushes one expected output record per
//   instance per cycle; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_anode_scanner;

   typedef struct packed {
      logic [3:0] anode;
      logic [1:0] idx;
      logic       tick;
   } exp_t;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   anode_scanner_if bus_a ();
   anode_scanner_if bus_b ();
   anode_scanner_if bus_c ();

   anode_scanner #(
      .DIV_COUNT    (8),
      .BLANK_CYCLES (2),
      .CNT_W        (4)
   ) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .scan    (bus_a.slave)
   );

   anode_scanner #(
      .DIV_COUNT    (8),
      .BLANK_CYCLES (0),
      .CNT_W        (4)
   ) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .scan    (bus_b.slave)
   );

   anode_scanner dut_c (
      .clk     (clk),
      .reset_n (reset_n),
      .scan    (bus_c.slave)
   );

   // 10-time-unit clock; posedges at 5, 15, 25, ...
   always #5 clk = ~clk;

   exp_t       q_a[$];
   exp_t       q_b[$];
   exp_t       q_c[$];
   int         checks = 0;
   int         errors = 0;
   logic       en_v[3];
   logic [3:0] mask_v[3];
   bit         run_v[3];
   int         k_v[3];

   // Slot geometry of each instance
   function automatic int divOf(input int i);
      return (i == 2) ? 100000 : 8;
   endfunction

   function automatic int blankOf(input int i);
      if (i == 0) return 2;
      if (i == 1) return 0;
      return 1000;
   endfunction

   // Drive one instance's inputs and remember them for the expectation model
   task automatic applyStimulus(input int i, input logic e, input logic [3:0] m);
      en_v[i]   = e;
      mask_v[i] = m;
      case (i)
         0:       begin bus_a.en = e; bus_a.digit_mask = m; end
         1:       begin bus_b.en = e; bus_b.digit_mask = m; end
         default: begin bus_c.en = e; bus_c.digit_mask = m; end
      endcase
   endtask

   task automatic applyAB(input logic e, input logic [3:0] m);
      applyStimulus(0, e, m);
      applyStimulus(1, e, m);
   endtask

   // k counts cycles since the first non-idle cycle of the current run
   task automatic modelEdge(input int i);
      if (!en_v[i]) begin
         run_v[i] = 1'b0;
         k_v[i]   = 0;
      end else if (!run_v[i]) begin
         run_v[i] = 1'b1;
         k_v[i]   = 0;
      end else begin
         k_v[i]++;
      end
   endtask

   function automatic exp_t modelExpect(input int i);
      exp_t       e;
      int         slot;
      int         off;
      logic [3:0] one;
      e.anode = 4'b1111;
      e.idx   = 2'd0;
      e.tick  = 1'b0;
      if (run_v[i]) begin
         slot   = (k_v[i] / divOf(i)) % 4;
         off    = k_v[i] % divOf(i);
         one    = 4'b0001 << slot;
         e.idx  = slot[1:0];
         e.tick = (off == divOf(i) - 1);
         if (off >= blankOf(i) && mask_v[i][slot]) begin
            e.anode = ~one;
         end
      end
      return e;
   endfunction

   task automatic pushExpect(input int i);
      exp_t e;
      e = modelExpect(i);
      case (i)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   // One clock edge; optionally pulse reset low between edges afterwards
   task automatic stepCycle(input bit pulse_reset);
      @(posedge clk);
      for (int i = 0; i < 3; i++) modelEdge(i);
      if (pulse_reset) begin
         #2;
         reset_n = 1'b0;
         for (int i = 0; i < 3; i++) begin
            run_v[i] = 1'b0;
            k_v[i]   = 0;
         end
      end else begin
         #1;
      end
      for (int i = 0; i < 3; i++) pushExpect(i);
      if (pulse_reset) begin
         @(negedge clk);
         #1;
         reset_n = 1'b1;
      end
   endtask

   task automatic steps(input int n);
      for (int s = 0; s < n; s++) stepCycle(1'b0);
   endtask

   task automatic checkOutput(input string name, input exp_t got, input exp_t want);
      checks += 3;
      if (got.anode !== want.anode) begin
         errors++;
         $display("[TB] FAIL %s.anode t=%0t got %b want %b", name, $time, got.anode, want.anode);
      end
      if (got.idx !== want.idx) begin
         errors++;
         $display("[TB] FAIL %s.digit_idx t=%0t got %0d want %0d", name, $time, got.idx, want.idx);
      end
      if (got.tick !== want.tick) begin
         errors++;
         $display("[TB] FAIL %s.tick t=%0t got %b want %b", name, $time, got.tick, want.tick);
      end
   endtask

   // Monitor: the DUT presents a fresh output every cycle; compare mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (q_a.size() != 0) begin
         e = q_a.pop_front();
         checkOutput("A", {bus_a.anode, bus_a.digit_idx, bus_a.tick}, e);
      end
      if (q_b.size() != 0) begin
         e = q_b.pop_front();
         checkOutput("B", {bus_b.anode, bus_b.digit_idx, bus_b.tick}, e);
      end
      if (q_c.size() != 0) begin
         e = q_c.pop_front();
         checkOutput("C", {bus_c.anode, bus_c.digit_idx, bus_c.tick}, e);
      end
   end

   // Stimulus
   initial begin
      for (int i = 0; i < 3; i++) begin
         run_v[i] = 1'b0;
         k_v[i]   = 0;
         applyStimulus(i, 1'b0, 4'b1111);
      end
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) pushExpect(i);
      @(negedge clk);
      #2;
      reset_n = 1'b1;
      stepCycle(1'b0);

      $display("[TB] full mask, continuous scan");
      for (int i = 0; i < 3; i++) applyStimulus(i, 1'b1, 4'b1111);
      steps(33);

      $display("[TB] mask 1010 on A/B");
      applyAB(1'b0, 4'b1111);
      stepCycle(1'b0);
      applyAB(1'b1, 4'b1010);
      steps(33);

      $display("[TB] en dropped during digit2 show");
      applyAB(1'b0, 4'b1111);
      stepCycle(1'b0);
      applyAB(1'b1, 4'b1111);
      steps(22);
      applyAB(1'b0, 4'b1111);
      steps(2);
      applyAB(1'b1, 4'b1111);
      steps(10);

      $display("[TB] mask change mid-slot");
      applyAB(1'b1, 4'b1101);
      steps(1);
      applyAB(1'b1, 4'b1111);
      steps(2);

      $display("[TB] async reset pulse mid-show");
      stepCycle(1'b1);
      steps(34);

      $display("[TB] default timing, first slot of C");
      for (int n = 0; n < 1200 && !(run_v[2] && k_v[2] >= 1005); n++) begin
         stepCycle(1'b0);
      end

      @(negedge clk);
      #1;
      checks++;
      if (q_a.size() + q_b.size() + q_c.size() != 0) begin
         errors++;
         $display("[TB] FAIL queue_drain got %0d pending want 0",
                  q_a.size() + q_b.size() + q_c.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Runaway guard
   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
